// File: rtl/gcd_arbiter.sv
// rtl/gcd_arbiter.sv - round-robin arbiter sharing one GCD core between two requesters
module gcd_arbiter #(
    parameter int W       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] x0,
    input  logic [W-1:0] y0,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] y1,
    output logic         ack0,
    output logic         ack1,
    output logic         valid0,
    output logic         valid1,
    output logic [W-1:0] res,
    output logic         err,
    output logic         busy,
    output logic         gcd_start,
    output logic [W-1:0] gcd_x,
    output logic [W-1:0] gcd_y,
    input  logic [W-1:0] gcd_result,
    input  logic         gcd_done
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t        state, state_d;
    logic          owner, owner_d;
    logic          last, last_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          aborted, aborted_d;
    logic [W-1:0]  x_d, y_d, res_d;
    logic          ack0_d, ack1_d, valid0_d, valid1_d, err_d, busy_d, start_d;
    logic          grant_k;
    logic [W-1:0]  gx, gy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            cnt       <= '0;
            aborted   <= 1'b0;
            gcd_x     <= '0;
            gcd_y     <= '0;
            res       <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            valid0    <= 1'b0;
            valid1    <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            gcd_start <= 1'b0;
        end else begin
            state     <= state_d;
            owner     <= owner_d;
            last      <= last_d;
            cnt       <= cnt_d;
            aborted   <= aborted_d;
            gcd_x     <= x_d;
            gcd_y     <= y_d;
            res       <= res_d;
            ack0      <= ack0_d;
            ack1      <= ack1_d;
            valid0    <= valid0_d;
            valid1    <= valid1_d;
            err       <= err_d;
            busy      <= busy_d;
            gcd_start <= start_d;
        end
    end

    always_comb begin
        state_d   = state;
        owner_d   = owner;
        last_d    = last;
        cnt_d     = cnt;
        aborted_d = aborted;
        x_d       = gcd_x;
        y_d       = gcd_y;
        res_d     = res;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        valid0_d  = 1'b0;
        valid1_d  = 1'b0;
        err_d     = 1'b0;
        start_d   = gcd_start;
        grant_k   = 1'b0;
        gx        = '0;
        gy        = '0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester not served last time wins
                    grant_k = (req0 && req1) ? ~last : req1;
                    gx      = grant_k ? x1 : x0;
                    gy      = grant_k ? y1 : y0;
                    owner_d = grant_k;
                    last_d  = grant_k;
                    x_d     = gx;
                    y_d     = gy;
                    ack0_d  = ~grant_k;
                    ack1_d  = grant_k;
                    if (gx == '0 || gy == '0) begin
                        res_d    = gx | gy;
                        valid0_d = ~grant_k;
                        valid1_d = grant_k;
                    end else begin
                        state_d = ISSUE;
                        start_d = 1'b1;
                        cnt_d   = '0;
                    end
                end
            end
            ISSUE: begin
                cnt_d = cnt + CW'(1);
                if (gcd_done) begin
                    res_d   = gcd_result;
                    start_d = 1'b0;
                    state_d = DRAIN;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    res_d     = '0;
                    aborted_d = 1'b1;
                    start_d   = 1'b0;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                // Hold off completion until the core has released done
                start_d = 1'b0;
                if (!gcd_done) begin
                    valid0_d  = ~owner;
                    valid1_d  = owner;
                    err_d     = aborted;
                    aborted_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

endmodule
